// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalize / round-to-nearest-even / pack to IEEE binary32.
// Define FP_NORM_FLAGS_EN to add the out_flags {overflow, underflow, inexact, zero} port.
module fp_norm_round #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data
`ifdef FP_NORM_FLAGS_EN
    ,
    output logic [3:0]        out_flags
`endif
);

    localparam int XW  = EXP_W + 1;
    localparam int FW  = EXP_W + 2;
    localparam int SW  = MANT_W - 2;
    localparam int FRW = MANT_W - 4;
    localparam int LZW = $clog2(MANT_W);

    logic           r_s1_valid;
    logic           r_s1_sign;
    logic           r_s1_zero;
    logic           r_s1_stk;
    logic [XW-1:0]  r_s1_exp;
    logic [SW-1:0]  r_s1_mant;

    logic           r_s2_valid;
    logic [31:0]    r_s2_data;

    logic           w_s1_adv;
    logic [LZW-1:0] w_lz;
    logic [XW-1:0]  w_exp_ext;
    logic [XW-1:0]  w_s1_exp;
    logic [SW-1:0]  w_s1_mant;
    logic           w_s1_stk;
    logic           w_s1_zero;

    logic [FRW-1:0] w_frac;
    logic           w_guard;
    logic           w_sticky;
    logic           w_inc;
    logic [FRW:0]   w_frac_sum;
    logic [FW-1:0]  w_exp_r;
    logic           w_ovf;
    logic           w_unf;
    logic [31:0]    w_s2_data;

    assign w_s1_adv  = ~r_s2_valid | out_ready;
    assign in_ready  = ~r_s1_valid | w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;

    // Highest set bit wins, so the last match in the ascending scan is the count.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < MANT_W - 1; i++) begin
            if (in_mant[i]) begin
                w_lz = LZW'(MANT_W - 2 - i);
            end
        end
    end

    assign w_exp_ext = {in_exp[EXP_W-1], in_exp};
    assign w_s1_zero = (in_mant == '0);

    always_comb begin
        w_s1_mant = SW'(in_mant << w_lz);
        w_s1_exp  = w_exp_ext - XW'(w_lz);
        w_s1_stk  = 1'b0;
        if (in_mant[MANT_W-1]) begin
            w_s1_mant = SW'(in_mant >> 1);
            w_s1_exp  = w_exp_ext + XW'(1);
            w_s1_stk  = in_mant[0];
        end
    end

    assign w_frac     = r_s1_mant[SW-1:2];
    assign w_guard    = r_s1_mant[1];
    assign w_sticky   = r_s1_mant[0] | r_s1_stk;
    assign w_inc      = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + (FRW+1)'(w_inc);
    assign w_exp_r    = {r_s1_exp[XW-1], r_s1_exp} + FW'(w_frac_sum[FRW]);
    assign w_unf      = w_exp_r[FW-1] | (w_exp_r == '0);
    assign w_ovf      = ~w_exp_r[FW-1] & (w_exp_r >= FW'(255));

    // On carry-out the sum's low bits are already zero.
    always_comb begin
        w_s2_data = {r_s1_sign, w_exp_r[7:0], w_frac_sum[FRW-1:0]};
        if (r_s1_zero || w_unf) begin
            w_s2_data = {r_s1_sign, 31'h0};
        end else if (w_ovf) begin
            w_s2_data = {r_s1_sign, 8'hFF, 23'h0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_stk   <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (in_ready && in_valid) begin
                r_s1_sign <= in_sign;
                r_s1_zero <= w_s1_zero;
                r_s1_stk  <= w_s1_stk;
                r_s1_exp  <= w_s1_exp;
                r_s1_mant <= w_s1_mant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv && r_s1_valid) begin
                r_s2_data <= w_s2_data;
            end
        end
    end

`ifdef FP_NORM_FLAGS_EN
    logic       w_nz;
    logic [3:0] w_flags;
    logic [3:0] r_flags;

    assign w_nz    = ~r_s1_zero;
    assign w_flags = {w_nz & ~w_unf & w_ovf,
                      w_nz & w_unf,
                      w_nz & (w_guard | w_sticky | w_unf),
                      r_s1_zero | w_unf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_s1_adv && r_s1_valid) begin
            r_flags <= w_flags;
        end
    end

    assign out_flags = r_flags;
`endif

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed vectors, pipeline corner sequences and a
// randomized stream scored against an arithmetic reference model.
module tb_fp_norm_round;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  f;
    } exp_t;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [26:0] m;
        logic [31:0] d;
        logic [3:0]  f;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [26:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef FP_NORM_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    fp_norm_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FP_NORM_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Reference: find the top bit, take a 24-bit significand, round the
    // discarded remainder to nearest-even against one half ulp.
    function automatic exp_t model(input logic s, input logic [9:0] e,
                                   input logic [26:0] m);
        exp_t r;
        int   p;
        int   big_e;
        int   q;
        int   rem;
        int   half;
        bit   inx;
        r.d = {s, 31'h0};
        r.f = 4'b0001;
        if (m == 27'h0) return r;
        p = 0;
        for (int i = 0; i < 27; i++) if (m[i]) p = i;
        big_e = int'($signed(e)) + p - 25;
        inx = 1'b0;
        if (p > 23) begin
            q    = int'(m) >> (p - 23);
            rem  = int'(m) - (q << (p - 23));
            half = 1 << (p - 24);
            inx  = (rem != 0);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end else begin
            q = int'(m) << (23 - p);
        end
        if (q == (1 << 24)) begin
            q = q >> 1;
            big_e++;
        end
        if (big_e >= 255) begin
            r.d = {s, 8'hFF, 23'h0};
            r.f = {1'b1, 1'b0, inx, 1'b0};
        end else if (big_e <= 0) begin
            r.d = {s, 31'h0};
            r.f = 4'b0111;
        end else begin
            r.d = {s, 8'(big_e), 23'(q)};
            r.f = {2'b00, inx, 1'b0};
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic s, input logic [9:0] e,
                                input logic [26:0] m, input logic [31:0] d,
                                input logic [3:0] f);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.d = d; v.f = f;
        return v;
    endfunction

    // Scoreboard: every accepted beat queues its model result; every cycle
    // with out_valid must show the queue head, which also covers stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h want none", out_data);
                end else begin
                    check("sb_data", out_data, exp_q[0].d);
`ifdef FP_NORM_FLAGS_EN
                    check("sb_flags", 32'(out_flags), 32'(exp_q[0].f));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_sign, in_exp, in_mant));
            end
        end
    end

    task automatic send(input logic s, input logic [9:0] e, input logic [26:0] m);
        int n;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    vec_t tv[$];
    int   lat;
    int   acc_cnt;
    int   fires;
    int   sent;
    int   cyc;
    bit   acc;
    int   seen;

    initial begin
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        tv.push_back(mk(0, 10'd127, 27'h2000000, 32'h3F800000, 4'b0000));
        tv.push_back(mk(0, 10'd127, 27'h4000000, 32'h40000000, 4'b0000));
        tv.push_back(mk(0, 10'd127, 27'h0000400, 32'h38000000, 4'b0000));
        tv.push_back(mk(1, 10'd127, 27'h0000000, 32'h80000000, 4'b0001));
        tv.push_back(mk(0, 10'd127, 27'h2000002, 32'h3F800000, 4'b0010));
        tv.push_back(mk(0, 10'd127, 27'h2000006, 32'h3F800002, 4'b0010));
        tv.push_back(mk(0, 10'd127, 27'h2000003, 32'h3F800001, 4'b0010));
        tv.push_back(mk(0, 10'd127, 27'h3FFFFFE, 32'h40000000, 4'b0010));
        tv.push_back(mk(0, 10'd127, 27'h4000004, 32'h40000000, 4'b0010));
        tv.push_back(mk(0, 10'd127, 27'h4000005, 32'h40000001, 4'b0010));
        tv.push_back(mk(0, 10'd254, 27'h4000000, 32'h7F800000, 4'b1000));
        tv.push_back(mk(0, 10'd253, 27'h3FFFFFF, 32'h7F000000, 4'b0010));
        tv.push_back(mk(0, 10'd1,   27'h1000000, 32'h00000000, 4'b0111));
        tv.push_back(mk(0, 10'h3FF, 27'h4000000, 32'h00000000, 4'b0111));
        tv.push_back(mk(1, 10'd126, 27'h0000001, 32'hB2800000, 4'b0000));
        tv.push_back(mk(1, 10'd127, 27'h2000000, 32'hBF800000, 4'b0000));

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'h0);
`ifdef FP_NORM_FLAGS_EN
        check("rst_flags", 32'(out_flags), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tv[k]) begin
            send(tv[k].s, tv[k].e, tv[k].m);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 20);
            check($sformatf("latency_%0d", k), 32'(lat), 32'd2);
            check($sformatf("vec_data_%0d", k), out_data, tv[k].d);
`ifdef FP_NORM_FLAGS_EN
            check($sformatf("vec_flags_%0d", k), 32'(out_flags), 32'(tv[k].f));
`endif
            @(posedge clk);
            #1;
        end

        // Backpressure: four beats offered with the sink stalled.
        acc_cnt = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            in_valid = (acc_cnt < 4);
            in_sign  = 1'b0;
            in_exp   = 10'(120 + acc_cnt);
            in_mant  = 27'h2000000 + 27'(acc_cnt * 8);
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
        end
        check("bp_accepted", 32'(acc_cnt), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        fires = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid  = (acc_cnt < 4);
            in_exp    = 10'(120 + acc_cnt);
            in_mant   = 27'h2000000 + 27'(acc_cnt * 8);
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) fires++;
        end
        check("bp_release_accepted", 32'(acc_cnt), 32'd4);
        check("bp_release_rate", 32'(fires), 32'd4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(0, 10'd130, 27'h2345678);
        send(1, 10'd100, 27'h0123456);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_stale", 32'(seen), 32'd0);

        // Randomized stream with random gaps and random backpressure.
        @(posedge clk);
        #1;
        sent = 0;
        acc  = 1'b1;
        cyc  = 0;
        while ((sent < 400 || in_valid) && cyc < 8000) begin
            @(posedge clk);
            #1;
            if (acc || !in_valid) begin
                if (sent < 400 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_sign  = 1'($urandom);
                    in_exp   = 10'(int'($urandom_range(0, 330)) - 40);
                    if ($urandom_range(0, 15) == 0) in_mant = '0;
                    else in_mant = 27'($urandom) >> $urandom_range(0, 26);
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            cyc++;
        end
        check("rand_finished", 32'(cyc < 8000), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-add/multiply normalize-and-round stage of the ex_stage FP datapath.
- Consumes an unnormalized 2.25 fixed-point mantissa, biased exponent and sign, and produces a packed IEEE-754 binary32 result.
- Normalization uses a leading-zero count over the mantissa; the implementation may reuse the team's lzc_* trees.
- Two-stage pipeline (normalize, then round/pack) with a valid/ready handshake on both sides.

Parameters:
- MANT_W, 27, input mantissa width. Format 2.25: bit 26 = 2^1, bit 25 = 2^0, bits 24..0 = fraction. Only the default is required to be supported.
- EXP_W, 10, input exponent width, two's-complement signed, biased by 127.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_sign  in  1  sign
- in_exp  in  EXP_W  signed biased exponent; value = mant/2^25 * 2^(in_exp-127)
- in_mant  in  MANT_W  unnormalized mantissa
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  32  packed binary32 result

Behaviour:
- Reset: the clock is clk. Reset is asynchronous and active-low on rst_n. During reset, all pipeline valid bits and data registers clear, so out_valid=0, out_data=0 and in_ready=1. Beats in flight at reset assertion are dropped.
- Handshake:
  - A beat transfers on in_valid&in_ready (input) and on out_valid&out_ready (output).
  - s1_adv = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s1_adv, combinational from registers and out_ready.
  - Throughput is 1 beat/cycle. Latency is 2 cycles from input accept to out_valid when out_ready=1.
  - out_data is held stable while out_valid=1 and out_ready=0. Beats are never reordered or dropped.
- Stage 1 (normalize), registered into s1:
  - in_mant==0: the beat is marked zero.
  - bit 26 set: shift right 1, exponent +1, and the shifted-out bit ORs into sticky.
  - Otherwise: lz = leading zeros counted from bit 25; shift left by lz; exponent -= lz.
  - Exponent arithmetic is done in EXP_W+1 bits with no wrap.
- Stage 2 (round/pack), registered into out_data:
  - Fields: frac = bits 24..2, guard = bit 1, sticky = bit 0 OR the stage-1 sticky.
  - Round to nearest even: increment when guard & (sticky | frac[0]).
  - Round carry-out (frac all ones) sets frac to 0 and increments the exponent.
  - Final exp >= 255: result is sign,8'hFF,23'h0 (signed infinity).
  - Final exp <= 0: flush to signed zero. Denormals are not produced.
  - Zero beat: result is sign,31'h0.
- Simultaneous input and output transfer in the same cycle is legal and keeps full throughput.

Optional Feature:
- Macro: FP_NORM_FLAGS_EN.
- Defined: adds port out_flags, out, 4 bits = {overflow, underflow, inexact, zero}.
  - Registered alongside out_data and valid with out_valid.
  - inexact = guard|sticky before rounding, or any flushed nonzero.
  - underflow = flush-to-zero of a nonzero value.
  - overflow = infinity produced.
  - zero = result magnitude 0.
  - Reset value is 0.
- Undefined: the port and the flag logic are absent. out_data behaviour is identical in both builds.

Test Plan:
- mant=27'h2000000, exp=127, sign=0 -> out_data=32'h3F800000, 2 cycles after accept. mant=27'h4000000, exp=127 -> 32'h40000000.
- mant=27'h0000400, exp=127 (lz=15) -> 32'h38000000. mant=0, sign=1 -> 32'h80000000, zero flag=1.
- Ties-to-even, exp=127:
  - mant=27'h2000002 -> 32'h3F800000, inexact=1.
  - mant=27'h2000006 -> 32'h3F800002.
  - mant=27'h3FFFFFE -> carry-out -> 32'h40000000.
- Overflow/underflow:
  - exp=254, mant=27'h4000000 -> 32'h7F800000, overflow=1.
  - exp=1, mant=27'h1000000 -> 32'h00000000, underflow=1.
- Backpressure: out_ready=0 while streaming 4 beats -> in_ready falls after 2 accepted. out_data is stable while stalled. On release, results emerge in order at 1/cycle.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, in_ready=1. No stale output appears after release.
